// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, FSM states,
// default exception codes and a constant-evaluable log2 helper.
package dm_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [4:0] EXC_ADEL_DEF = 5'd4;
  localparam logic [4:0] EXC_ADES_DEF = 5'd5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Byte-lane steering: store enables/replication/misalignment for the request
// in flight, and extract/extend of a read word using the registered load info.
module dm_lane_ctrl
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sext,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Reserved size 2'b11 falls into the word arm on both paths.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = lane[0];
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = |lane;
      end
    endcase
  end

  always_comb begin
    ld_b    = ld_word[{ld_lane, 3'b000} +: 8];
    ld_h    = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_size)
      SIZE_B:  ld_data = ld_sext ? {{24{ld_b[7]}}, ld_b} : {24'h0, ld_b};
      SIZE_H:  ld_data = ld_sext ? {{16{ld_h[15]}}, ld_h} : {16'h0, ld_h};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dm_bytelane_sync.sv
// MEM-stage data RAM: byte-lane stores, extended sub-word loads (latency 1),
// range/alignment exceptions, and a one-word-per-cycle clear after reset.
module dm_bytelane_sync
  import dm_pkg::*;
#(
  parameter int          DEPTH    = 2048,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter logic [4:0]  EXC_ADEL = EXC_ADEL_DEF,
  parameter logic [4:0]  EXC_ADES = EXC_ADES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_addr
);

  localparam int          AW   = clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  state_t          state, state_nx;
  logic [AW-1:0]   clr_idx;
  logic            clr_we;

  logic            acc, range_err, misalign, err, st_we, ld_acc;
  logic [32:0]     off;
  logic [AW-1:0]   idx, waddr;
  logic [3:0]      be, wr_en;
  logic [31:0]     wdata_rep, wbus, ld_word;
  logic [7:0]      ram_q [4];
  logic [1:0]      ld_size, ld_lane;
  logic            ld_sext;

  // 33-bit offset: an address below BASE wraps to a huge value and fails the span test.
  assign off       = {1'b0, addr} - {1'b0, BASE};
  assign range_err = off >= SPAN;
  assign idx       = off[AW+1:2];
  assign err       = range_err || misalign;
  assign acc       = req && ready;
  assign st_we     = acc && we && !err;
  assign ld_acc    = acc && !we && !err;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_idx == AW'(DEPTH - 1)) state_nx = RUN;
  end

  always_comb begin
    ready  = (state == RUN) && !reset;
    clr_we = (state == CLEAR) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset)       clr_idx <= '0;
    else if (clr_we) clr_idx <= clr_idx + 1'b1;
  end

  dm_lane_ctrl u_lane (
    .size      (size),
    .lane      (addr[1:0]),
    .wdata     (wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .misalign  (misalign),
    .ld_size   (ld_size),
    .ld_lane   (ld_lane),
    .ld_sext   (ld_sext),
    .ld_word   (ld_word),
    .ld_data   (rdata)
  );

  assign waddr = clr_we ? clr_idx : idx;
  assign wbus  = clr_we ? 32'h0 : wdata_rep;
  assign wr_en = {4{clr_we}} | ({4{st_we}} & be);

  // One byte-wide array per lane so each lane writes independently.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en[l]) mem[waddr] <= wbus[8*l +: 8];
    end
    assign ram_q[l] = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid    <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= '0;
      exc_pc    <= '0;
      exc_addr  <= '0;
      ld_word   <= '0;
      ld_size   <= SIZE_B;
      ld_lane   <= '0;
      ld_sext   <= 1'b0;
    end else begin
      rvalid    <= ld_acc;
      exc_valid <= acc && err;
      if (acc && err) begin
        exc_code <= we ? EXC_ADES : EXC_ADEL;
        exc_pc   <= pc;
        exc_addr <= addr;
      end
      // rdata is derived from these, so it holds until the next load lands.
      if (ld_acc) begin
        ld_word <= {ram_q[3], ram_q[2], ram_q[1], ram_q[0]};
        ld_size <= size;
        ld_lane <= addr[1:0];
        ld_sext <= sext;
      end
    end
  end

endmodule
